// File: rtl/regfile_write_queue_if.sv
// Bundle between the two writeback producers, the register-file write port
// and the forwarding lookup of regfile_write_queue.
interface regfile_write_queue_if #(
  parameter int REGWIDTH = 16,
  parameter int DEPTH    = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                alu_valid;
  logic [2:0]          alu_reg;
  logic [REGWIDTH-1:0] alu_data;
  logic                alu_ready;
  logic                mem_valid;
  logic [2:0]          mem_reg;
  logic [REGWIDTH-1:0] mem_data;
  logic                mem_ready;
  logic                writeEn;
  logic [2:0]          writeRegSel;
  logic [REGWIDTH-1:0] writeData;
  logic [2:0]          fwd_sel;
  logic                fwd_hit;
  logic [REGWIDTH-1:0] fwd_data;
  logic [CW-1:0]       count;
  logic                err;

  modport master (
    output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, fwd_sel,
    input  alu_ready, mem_ready, writeEn, writeRegSel, writeData,
           fwd_hit, fwd_data, count, err
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, fwd_sel,
    output alu_ready, mem_ready, writeEn, writeRegSel, writeData,
           fwd_hit, fwd_data, count, err
  );
endinterface

// File: rtl/regfile_write_queue.sv
// Serialises ALU and load writebacks onto the single register-file write port,
// with a forwarding lookup over writes still waiting in the queue.
module regfile_write_queue #(
  parameter int REGWIDTH = 16,
  parameter int DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_write_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]       head_reg, head_next;
  logic [PW-1:0]       tail_reg, tail_next;
  logic [CW-1:0]       count_reg, count_next;
  logic                err_reg, err_next;
  logic [2:0]          tag_mem  [DEPTH];
  logic [REGWIDTH-1:0] data_mem [DEPTH];

  logic                mem_ready, alu_ready;
  logic                mem_push, alu_push, pop;
  logic [PW-1:0]       alu_slot;

  // Readiness looks at occupancy only; the load path owns the last free slot.
  assign mem_ready = count_reg < CW'(DEPTH);
  assign alu_ready = (count_reg < CW'(DEPTH - 1)) |
                     ((count_reg == CW'(DEPTH - 1)) & ~bus.mem_valid);

  assign mem_push  = bus.mem_valid & mem_ready;
  assign alu_push  = bus.alu_valid & alu_ready;
  assign pop       = count_reg != '0;

  // The load entry is older, so the ALU entry lands one slot behind it.
  assign alu_slot   = tail_reg + PW'(mem_push);
  assign head_next  = head_reg + PW'(pop);
  assign tail_next  = tail_reg + PW'(mem_push) + PW'(alu_push);
  assign count_next = count_reg + CW'(mem_push) + CW'(alu_push) - CW'(pop);
  assign err_next   = mem_push & alu_push & (bus.mem_reg == bus.alu_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      err_reg   <= err_next;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_push) begin
      tag_mem[tail_reg]  <= bus.mem_reg;
      data_mem[tail_reg] <= bus.mem_data;
    end
    if (alu_push) begin
      tag_mem[alu_slot]  <= bus.alu_reg;
      data_mem[alu_slot] <= bus.alu_data;
    end
  end

  // Per-age lookup: offset gi from the head, valid only below the occupancy.
  logic [DEPTH-1:0]    fwd_match;
  logic [REGWIDTH-1:0] fwd_cand [DEPTH];
  logic                fwd_hit;
  logic [REGWIDTH-1:0] fwd_data;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_fwd
      logic [PW-1:0] slot;
      assign slot          = head_reg + PW'(gi);
      assign fwd_match[gi] = (CW'(gi) < count_reg) && (tag_mem[slot] == bus.fwd_sel);
      assign fwd_cand[gi]  = data_mem[slot];
    end
  endgenerate

  // Younger offsets override older ones, so the entry nearest the tail wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fwd_match[i]) begin
        fwd_hit  = 1'b1;
        fwd_data = fwd_cand[i];
      end
    end
  end

  assign bus.mem_ready   = mem_ready;
  assign bus.alu_ready   = alu_ready;
  assign bus.writeEn     = pop;
  assign bus.writeRegSel = tag_mem[head_reg];
  assign bus.writeData   = data_mem[head_reg];
  assign bus.fwd_hit     = fwd_hit;
  assign bus.fwd_data    = fwd_data;
  assign bus.count       = count_reg;
  assign bus.err         = err_reg;
endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed and random checks of regfile_write_queue against a queue-based
// reference model of the pending register writes.
module tb_regfile_write_queue;
  localparam int RW = 16;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_write_queue_if #(.REGWIDTH(RW), .DEPTH(D)) bus();

  regfile_write_queue #(.REGWIDTH(RW), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [2:0]    r;
    logic [RW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic          err_exp = 1'b0;
  logic [RW-1:0] obs_rf [8];
  logic [RW-1:0] exp_rf [8];
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic mv, input logic [2:0] mr, input logic [RW-1:0] md,
                       input logic av, input logic [2:0] ar, input logic [RW-1:0] ad);
    bus.mem_valid = mv; bus.mem_reg = mr; bus.mem_data = md;
    bus.alu_valid = av; bus.alu_reg = ar; bus.alu_data = ad;
  endtask

  // Compare every output with the model, then record any commit seen on the port.
  task automatic settle_check();
    int            n;
    logic          hit;
    logic [RW-1:0] fd;
    #1;
    n = q.size();
    chk("count", 32'(bus.count), 32'(n));
    chk("writeEn", 32'(bus.writeEn), 32'(n != 0));
    if (n != 0) begin
      chk("writeRegSel", 32'(bus.writeRegSel), 32'(q[0].r));
      chk("writeData", 32'(bus.writeData), 32'(q[0].d));
    end
    chk("mem_ready", 32'(bus.mem_ready), 32'(n < D));
    chk("alu_ready", 32'(bus.alu_ready), 32'((n < D - 1) || (n == D - 1 && !bus.mem_valid)));
    hit = 1'b0;
    fd  = '0;
    for (int i = 0; i < n; i++) begin
      if (q[i].r == bus.fwd_sel) begin
        hit = 1'b1;
        fd  = q[i].d;
      end
    end
    chk("fwd_hit", 32'(bus.fwd_hit), 32'(hit));
    chk("fwd_data", 32'(bus.fwd_data), 32'(fd));
    chk("err", 32'(bus.err), 32'(err_exp));
    if (bus.writeEn === 1'b1) obs_rf[bus.writeRegSel] = bus.writeData;
  endtask

  // Advance one clock and update the model: pop the oldest, then append load, then ALU.
  task automatic tick();
    int            n;
    logic          ma, aa;
    logic [2:0]    mr, ar;
    logic [RW-1:0] md, ad;
    ent_t          e;
    n  = q.size();
    ma = bus.mem_valid && (n < D);
    aa = bus.alu_valid && ((n < D - 1) || (n == D - 1 && !bus.mem_valid));
    mr = bus.mem_reg; md = bus.mem_data;
    ar = bus.alu_reg; ad = bus.alu_data;
    @(posedge clk);
    if (n != 0) begin
      exp_rf[q[0].r] = q[0].d;
      q.delete(0);
    end
    if (ma) begin e.r = mr; e.d = md; q.push_back(e); end
    if (aa) begin e.r = ar; e.d = ad; q.push_back(e); end
    err_exp = ma && aa && (mr == ar);
    @(negedge clk);
  endtask

  task automatic drain();
    drive(1'b0, 3'd0, '0, 1'b0, 3'd0, '0);
    for (int i = 0; i < D + 1; i++) begin
      settle_check();
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic mem_hold, alu_hold;
    int   n;
    drive(1'b0, 3'd0, '0, 1'b0, 3'd0, '0);
    bus.fwd_sel = 3'd0;
    for (int i = 0; i < 8; i++) begin obs_rf[i] = '0; exp_rf[i] = '0; end

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_writeEn", 32'(bus.writeEn), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_fwd_hit", 32'(bus.fwd_hit), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single ALU write and its latency
    drive(1'b0, 3'd0, '0, 1'b1, 3'd3, 16'h1234);
    settle_check(); tick();
    drive(1'b0, 3'd0, '0, 1'b0, 3'd0, '0);
    settle_check();
    chk("t1_writeEn", 32'(bus.writeEn), 32'd1);
    chk("t1_sel", 32'(bus.writeRegSel), 32'd3);
    chk("t1_data", 32'(bus.writeData), 32'h1234);
    chk("t1_count", 32'(bus.count), 32'd1);
    tick();
    settle_check();
    chk("t1_idle", 32'(bus.writeEn), 32'd0);
    tick();

    // Dual push: load entry drains first
    drive(1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'h5555);
    settle_check(); tick();
    drive(1'b0, 3'd0, '0, 1'b0, 3'd0, '0);
    settle_check();
    chk("t2_first_sel", 32'(bus.writeRegSel), 32'd1);
    chk("t2_first_data", 32'(bus.writeData), 32'hAAAA);
    chk("t2_err", 32'(bus.err), 32'd0);
    tick();
    settle_check();
    chk("t2_second_sel", 32'(bus.writeRegSel), 32'd2);
    chk("t2_second_data", 32'(bus.writeData), 32'h5555);
    tick();
    drain();

    // Last slot goes to the load path; the stalled ALU write lands later
    drive(1'b1, 3'd6, 16'h1111, 1'b1, 3'd7, 16'h2222);
    settle_check(); tick();
    drive(1'b1, 3'd6, 16'h3333, 1'b1, 3'd7, 16'h4444);
    settle_check(); tick();
    drive(1'b1, 3'd0, 16'h5555, 1'b1, 3'd1, 16'h6666);
    settle_check();
    chk("t3_count", 32'(bus.count), 32'd3);
    chk("t3_mem_ready", 32'(bus.mem_ready), 32'd1);
    chk("t3_alu_ready", 32'(bus.alu_ready), 32'd0);
    tick();
    drive(1'b0, 3'd0, '0, 1'b1, 3'd1, 16'h6666);
    settle_check();
    chk("t3_count_after", 32'(bus.count), 32'd3);
    chk("t3_alu_ready_later", 32'(bus.alu_ready), 32'd1);
    tick();
    drain();

    // Forwarding picks the youngest match
    drive(1'b1, 3'd5, 16'h0001, 1'b1, 3'd5, 16'h0002);
    settle_check(); tick();
    drive(1'b0, 3'd0, '0, 1'b0, 3'd0, '0);
    bus.fwd_sel = 3'd5;
    settle_check();
    chk("t4_hit", 32'(bus.fwd_hit), 32'd1);
    chk("t4_data", 32'(bus.fwd_data), 32'h0002);
    bus.fwd_sel = 3'd6;
    settle_check();
    chk("t4_miss_hit", 32'(bus.fwd_hit), 32'd0);
    chk("t4_miss_data", 32'(bus.fwd_data), 32'h0000);
    tick();
    drain();

    // Same-register collision pulses err once; ALU value is the last commit
    drive(1'b1, 3'd4, 16'h0BAD, 1'b1, 3'd4, 16'hBEEF);
    settle_check(); tick();
    drive(1'b0, 3'd0, '0, 1'b0, 3'd0, '0);
    settle_check();
    chk("t5_err_pulse", 32'(bus.err), 32'd1);
    tick();
    settle_check();
    chk("t5_err_clear", 32'(bus.err), 32'd0);
    tick();
    drain();
    chk("t5_commit", 32'(obs_rf[4]), 32'hBEEF);

    // Random traffic; a producer that is refused holds its request
    mem_hold = 1'b0;
    alu_hold = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!mem_hold) begin
        bus.mem_valid = 1'($urandom_range(0, 1));
        bus.mem_reg   = 3'($urandom_range(0, 7));
        bus.mem_data  = RW'($urandom);
      end
      if (!alu_hold) begin
        bus.alu_valid = 1'($urandom_range(0, 1));
        bus.alu_reg   = 3'($urandom_range(0, 7));
        bus.alu_data  = RW'($urandom);
      end
      bus.fwd_sel = 3'($urandom_range(0, 7));
      n = q.size();
      mem_hold = bus.mem_valid && !(n < D);
      alu_hold = bus.alu_valid && !((n < D - 1) || (n == D - 1 && !bus.mem_valid));
      settle_check();
      tick();
    end
    drain();
    for (int i = 0; i < 8; i++) chk("rf_final", 32'(obs_rf[i]), 32'(exp_rf[i]));

    // Sustained traffic wraps the pointers, then reset lands mid-drain
    for (int c = 0; c < 14; c++) begin
      drive(1'b1, 3'($urandom_range(0, 7)), RW'($urandom),
            1'b1, 3'($urandom_range(0, 7)), RW'($urandom));
      settle_check(); tick();
    end
    drive(1'b0, 3'd0, '0, 1'b0, 3'd0, '0);
    settle_check();
    chk("t6_busy", 32'(bus.writeEn), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_rst_writeEn", 32'(bus.writeEn), 32'd0);
    chk("t6_rst_count", 32'(bus.count), 32'd0);
    chk("t6_rst_err", 32'(bus.err), 32'd0);
    q.delete();
    err_exp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle_check();
      chk("t6_no_write", 32'(bus.writeEn), 32'd0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
